// File: rtl/dlx_stage_link.sv
// Decode-to-execute elastic link for the DLX pipeline: a DEPTH-entry valid/ready buffer of ALU bundles.
// Optional stall statistics (stall_cnt, full_seen) are enabled with `define DLX_STAGE_LINK_STALL_CNT_EN.
module dlx_stage_link #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int SHAMT_W = 5,
    parameter int DEPTH   = 2,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_aluin1,
    input  logic [DATA_W-1:0]  in_aluin2,
    input  logic [OP_W-1:0]    in_operation,
    input  logic [OP_W-1:0]    in_opselect,
    input  logic [SHAMT_W-1:0] in_shift_number,
    input  logic               in_enable_arith,
    input  logic               in_enable_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_aluin1,
    output logic [DATA_W-1:0]  out_aluin2,
    output logic [OP_W-1:0]    out_operation,
    output logic [OP_W-1:0]    out_opselect,
    output logic [SHAMT_W-1:0] out_shift_number,
    output logic               out_enable_arith,
    output logic               out_enable_shift,
    output logic [CW-1:0]      count
`ifdef DLX_STAGE_LINK_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic               full_seen
`endif
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0]  aluin1;
        logic [DATA_W-1:0]  aluin2;
        logic [OP_W-1:0]    operation;
        logic [OP_W-1:0]    opselect;
        logic [SHAMT_W-1:0] shift_number;
        logic               enable_arith;
        logic               enable_shift;
    } bundle_t;

    bundle_t          entry_p0 [DEPTH];
    bundle_t          in_bundle;
    bundle_t          head_p1;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    assign in_bundle = '{in_aluin1, in_aluin2, in_operation, in_opselect,
                         in_shift_number, in_enable_arith, in_enable_shift};

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    // Control state: in_ready and out_valid are registered from the next occupancy,
    // so in_ready never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            in_ready  <= (count_nxt < CW'(DEPTH));
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Stage p0: bundle storage, data only, no reset.
    always_ff @(posedge clk) begin
        if (push)
            entry_p0[wr_ptr] <= in_bundle;
    end

    // Stage p1: head selection; masking by out_valid keeps bubbles inert and zero after reset.
    assign head_p1 = out_valid ? entry_p0[rd_ptr] : '0;

    assign out_aluin1       = head_p1.aluin1;
    assign out_aluin2       = head_p1.aluin2;
    assign out_operation    = head_p1.operation;
    assign out_opselect     = head_p1.opselect;
    assign out_shift_number = head_p1.shift_number;
    assign out_enable_arith = head_p1.enable_arith;
    assign out_enable_shift = head_p1.enable_shift;

`ifdef DLX_STAGE_LINK_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            full_seen <= 1'b0;
        end else if (flush) begin
            stall_cnt <= '0;
            full_seen <= 1'b0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (in_valid && !in_ready)
                full_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dlx_stage_link.sv
// Directed self-checking bench for dlx_stage_link at default parameters (DEPTH=2).
module tb_dlx_stage_link;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 3;
    localparam int SHAMT_W = 5;
    localparam int DEPTH   = 2;
    localparam int CW      = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_aluin1;
    logic [DATA_W-1:0]  in_aluin2;
    logic [OP_W-1:0]    in_operation;
    logic [OP_W-1:0]    in_opselect;
    logic [SHAMT_W-1:0] in_shift_number;
    logic               in_enable_arith;
    logic               in_enable_shift;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_aluin1;
    logic [DATA_W-1:0]  out_aluin2;
    logic [OP_W-1:0]    out_operation;
    logic [OP_W-1:0]    out_opselect;
    logic [SHAMT_W-1:0] out_shift_number;
    logic               out_enable_arith;
    logic               out_enable_shift;
    logic [CW-1:0]      count;
`ifdef DLX_STAGE_LINK_STALL_CNT_EN
    logic [15:0]        stall_cnt;
    logic               full_seen;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dlx_stage_link #(.DATA_W(DATA_W), .OP_W(OP_W), .SHAMT_W(SHAMT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluin1(in_aluin1), .in_aluin2(in_aluin2),
        .in_operation(in_operation), .in_opselect(in_opselect),
        .in_shift_number(in_shift_number),
        .in_enable_arith(in_enable_arith), .in_enable_shift(in_enable_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluin1(out_aluin1), .out_aluin2(out_aluin2),
        .out_operation(out_operation), .out_opselect(out_opselect),
        .out_shift_number(out_shift_number),
        .out_enable_arith(out_enable_arith), .out_enable_shift(out_enable_shift),
        .count(count)
`ifdef DLX_STAGE_LINK_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .full_seen(full_seen)
`endif
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_aluin1 = '0; in_aluin2 = '0; in_operation = '0; in_opselect = '0;
        in_shift_number = '0; in_enable_arith = 1'b0; in_enable_shift = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({out_aluin1, out_enable_arith, out_enable_shift} !== '0) begin errors++; $display("FAIL reset_fields: got %h/%b/%b want 0", out_aluin1, out_enable_arith, out_enable_shift); end
        tick();
        rst = 1'b0;
        tick();
        // Fill to count=2, then reset asynchronously between edges.
        in_valid = 1'b1; in_enable_arith = 1'b1; in_aluin1 = 32'h55;
        tick();
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL prereset_count: got %0d want 2", count); end
        checks++; if (out_enable_arith !== 1'b1) begin errors++; $display("FAIL prereset_arith: got %b want 1", out_enable_arith); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL midreset_count: got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_enable_arith !== 1'b0) begin errors++; $display("FAIL midreset_arith: got %b want 0", out_enable_arith); end
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL postreset_no_survivor: got %b want 0", out_valid); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_aluin1 = 32'h0000_0005; in_aluin2 = 32'h0000_0003;
        in_operation = 3'b001; in_opselect = 3'b010; in_shift_number = 5'd4;
        in_enable_arith = 1'b1; in_enable_shift = 1'b0;
        tick();
        idle_inputs();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if ({out_aluin1, out_aluin2} !== {32'h5, 32'h3}) begin errors++; $display("FAIL single_operands: got %h %h want 5 3", out_aluin1, out_aluin2); end
        checks++; if ({out_operation, out_opselect, out_shift_number, out_enable_arith, out_enable_shift} !== {3'b001, 3'b010, 5'd4, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_ctrl: got %b %b %0d %b %b want 001 010 4 1 0", out_operation, out_opselect, out_shift_number, out_enable_arith, out_enable_shift);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
        checks++; if ({out_enable_arith, out_enable_shift} !== 2'b00) begin errors++; $display("FAIL single_bubble_en: got %b%b want 00", out_enable_arith, out_enable_shift); end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0; in_valid = 1'b1;
        in_aluin1 = 32'h11; tick();
        checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_a: got count=%0d rdy=%b want 1 1", count, in_ready); end
        in_aluin1 = 32'h22; tick();
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_b: got count=%0d rdy=%b want 2 0", count, in_ready); end
        in_aluin1 = 32'h33; tick();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL fill_c_refused: got count=%0d want 2", count); end
        checks++; if (out_aluin1 !== 32'h11) begin errors++; $display("FAIL fill_stall_hold: got %h want 11", out_aluin1); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_aluin1 !== 32'h22 || count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_b: got %h count=%0d rdy=%b want 22 1 1", out_aluin1, count, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL drain_empty: got v=%b count=%0d want 0 0", out_valid, count); end
        // Popping an empty link must not underflow.
        tick();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL empty_pop_ignored: got %0d want 0", count); end
        idle_inputs();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_aluin1 = i;
            tick();
            checks++;
            if (out_aluin1 !== 32'(i) || count !== 2'd1 || out_valid !== 1'b1) begin
                errors++; $display("FAIL stream_%0d: got %0d count=%0d v=%b want %0d 1 1", i, out_aluin1, count, out_valid, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL stream_drain: got %0d want 0", count); end
        idle_inputs();
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_aluin1 = 32'hA1; tick();
        in_aluin1 = 32'hA2; tick();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d want 2", count); end
        flush = 1'b1; out_ready = 1'b1; in_aluin1 = 32'hA3;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got count=%0d v=%b rdy=%b want 0 0 1", count, out_valid, in_ready);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost: got %b want 0", out_valid); end
        out_ready = 1'b0; in_valid = 1'b1; in_aluin1 = 32'hB1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_aluin1 !== 32'hB1 || count !== 2'd1) begin errors++; $display("FAIL flush_resume: got %h count=%0d want b1 1", out_aluin1, count); end
        out_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

`ifdef DLX_STAGE_LINK_STALL_CNT_EN
    task automatic test_stall_cnt();
        flush = 1'b1; tick(); flush = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0; in_aluin1 = 32'h77;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL stall_cnt_7: got %0d want 7", stall_cnt); end
        in_valid = 1'b1;
        tick();
        checks++; if (full_seen !== 1'b0) begin errors++; $display("FAIL full_seen_early: got %b want 0", full_seen); end
        tick();
        in_valid = 1'b0;
        checks++; if (full_seen !== 1'b1 || stall_cnt !== 16'd9) begin errors++; $display("FAIL full_seen_set: got %b cnt=%0d want 1 9", full_seen, stall_cnt); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (stall_cnt !== 16'd0 || full_seen !== 1'b0) begin errors++; $display("FAIL stall_flush_clear: got %0d %b want 0 0", stall_cnt, full_seen); end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_streaming();
        test_flush();
`ifdef DLX_STAGE_LINK_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
